// File: rtl/alu_pipe.sv
// Handshaked ALU with 16-op decode and {N,Z,C,V} flags.
// MUL/DIVU/REMU iterate one bit per cycle; one operation is in flight at a time.
module alu_pipe #(
  parameter int unsigned WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags,
  output logic             out_valid,
  input  logic             out_ready
);
  localparam int unsigned SHW = $clog2(WIDTH);

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_MUL  = 4'hB;
  localparam logic [3:0] OP_DIVU = 4'hC;
  localparam logic [3:0] OP_REMU = 4'hD;
  localparam logic [3:0] OP_RSVD = 4'hF;

  typedef enum logic {IDLE, BUSY} state_e;

  state_e           state, state_nxt;
  logic [SHW-1:0]   cnt;
  logic [3:0]       op_q;
  logic [WIDTH-1:0] acc, x, y;
  logic             accept, iter_op, last;
  logic [WIDTH:0]   sum, diff, rem_sh;
  logic [WIDTH-1:0] s_res;
  logic [3:0]       s_flags;
  logic             s_c, s_v;
  logic [WIDTH-1:0] i_acc, i_x, i_y, i_res;

  assign in_ready = !rst && (state == IDLE) && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign iter_op  = (op == OP_MUL) || (op == OP_DIVU) || (op == OP_REMU);
  assign last     = (state == BUSY) && (cnt == SHW'(WIDTH - 1));

  // Single-cycle ops, evaluated straight from the input operands
  always_comb begin
    sum   = {1'b0, a} + {1'b0, b};
    diff  = {1'b0, a} - {1'b0, b};
    s_res = '0;
    s_c   = 1'b0;
    s_v   = 1'b0;
    case (op)
      OP_ADD: begin
        s_res = sum[WIDTH-1:0];
        s_c   = sum[WIDTH];
        s_v   = (a[WIDTH-1] == b[WIDTH-1]) && (s_res[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        s_res = diff[WIDTH-1:0];
        s_c   = !diff[WIDTH];
        s_v   = (a[WIDTH-1] != b[WIDTH-1]) && (s_res[WIDTH-1] != a[WIDTH-1]);
      end
      4'h2:    s_res = a & b;
      4'h3:    s_res = a | b;
      4'h4:    s_res = a ^ b;
      4'h5:    s_res = ~(a | b);
      4'h6:    s_res = a << b[SHW-1:0];
      4'h7:    s_res = a >> b[SHW-1:0];
      4'h8:    s_res = $signed(a) >>> b[SHW-1:0];
      4'h9:    s_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      4'hA:    s_res = {{(WIDTH-1){1'b0}}, (a < b)};
      4'hE:    s_res = b;
      default: s_res = '0;
    endcase
    s_flags = (op == OP_RSVD) ? 4'b0000 : {s_res[WIDTH-1], (s_res == '0), s_c, s_v};
  end

  // One shift-add or restoring-divide step on the held operands
  always_comb begin
    i_acc  = acc;
    i_x    = x;
    i_y    = y;
    rem_sh = {acc, x[WIDTH-1]};
    if (op_q == OP_MUL) begin
      if (y[0]) i_acc = acc + x;
      i_x = {x[WIDTH-2:0], 1'b0};
      i_y = {1'b0, y[WIDTH-1:1]};
    end else begin
      i_x   = {x[WIDTH-2:0], 1'b0};
      i_acc = rem_sh[WIDTH-1:0];
      if (rem_sh >= {1'b0, y}) begin
        i_acc  = WIDTH'(rem_sh - {1'b0, y});
        i_x[0] = 1'b1;
      end
    end
    i_res = (op_q == OP_DIVU) ? i_x : i_acc;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept && iter_op) state_nxt = BUSY;
      BUSY:    if (last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // The last iteration and the output load share one edge
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      op_q      <= '0;
      acc       <= '0;
      x         <= '0;
      y         <= '0;
      result    <= '0;
      flags     <= '0;
      out_valid <= 1'b0;
    end else begin
      if (accept && iter_op) begin
        op_q <= op;
        acc  <= '0;
        x    <= a;
        y    <= b;
        cnt  <= '0;
      end else if (state == BUSY) begin
        acc <= i_acc;
        x   <= i_x;
        y   <= i_y;
        cnt <= cnt + 1'b1;
      end

      if (accept && !iter_op) begin
        result    <= s_res;
        flags     <= s_flags;
        out_valid <= 1'b1;
      end else if (last) begin
        result    <= i_res;
        flags     <= {i_res[WIDTH-1], (i_res == '0), 2'b00};
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_alu_pipe.sv
// Bench for alu_pipe: WIDTH=64 and WIDTH=8 instances checked against an arithmetic model.
module tb_alu_pipe;
  typedef struct packed {logic [63:0] r; logic [3:0] f;} res_t;
  typedef struct {res_t e; int ready_at;} exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sel = 1'b0;
  logic [63:0] a = '0, b = '0;
  logic [3:0]  op = '0;
  logic        in_valid = 1'b1;
  logic        out_ready = 1'b1;
  logic        ready_force = 1'b1;
  logic        rnd_ready = 1'b0;

  logic        iv64, iv8, ir64, ir8, ov64, ov8;
  logic [63:0] r64;
  logic [7:0]  r8;
  logic [3:0]  f64, f8;
  logic        obs_ir, obs_ov;
  logic [63:0] obs_r;
  logic [3:0]  obs_f;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  assign iv64   = in_valid & ~sel;
  assign iv8    = in_valid & sel;
  assign obs_ir = sel ? ir8 : ir64;
  assign obs_ov = sel ? ov8 : ov64;
  assign obs_r  = sel ? {56'd0, r8} : r64;
  assign obs_f  = sel ? f8 : f64;

  alu_pipe #(.WIDTH(64)) u_alu64 (
    .clk(clk), .rst(rst), .a(a), .b(b), .op(op), .in_valid(iv64), .in_ready(ir64),
    .result(r64), .flags(f64), .out_valid(ov64), .out_ready(out_ready)
  );

  alu_pipe #(.WIDTH(8)) u_alu8 (
    .clk(clk), .rst(rst), .a(a[7:0]), .b(b[7:0]), .op(op), .in_valid(iv8), .in_ready(ir8),
    .result(r8), .flags(f8), .out_valid(ov8), .out_ready(out_ready)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic signed [65:0] sx(input logic [63:0] v, input int w);
    logic signed [65:0] s;
    s = $signed({2'b00, v});
    if (v[w-1]) s = s - (66'sd1 <<< w);
    return s;
  endfunction

  // Reference: plain w-bit modular arithmetic
  function automatic res_t model(input int w, input logic [63:0] ai, input logic [63:0] bi,
                                 input logic [3:0] o);
    logic [63:0] m, aa, bb, r;
    logic signed [65:0] sa, sb, s, lim;
    logic c, v;
    int sh;
    res_t res;
    m   = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    aa  = ai & m;
    bb  = bi & m;
    sa  = sx(aa, w);
    sb  = sx(bb, w);
    lim = 66'sd1 <<< (w - 1);
    sh  = int'(bb[5:0]) % w;
    c = 1'b0; v = 1'b0; r = '0;
    case (o)
      4'h0: begin
        r = aa + bb; c = (65'(aa) + 65'(bb)) > 65'(m);
        s = sa + sb; v = (s >= lim) || (s < -lim);
      end
      4'h1: begin
        r = aa - bb; c = aa >= bb;
        s = sa - sb; v = (s >= lim) || (s < -lim);
      end
      4'h2: r = aa & bb;
      4'h3: r = aa | bb;
      4'h4: r = aa ^ bb;
      4'h5: r = ~(aa | bb);
      4'h6: r = aa << sh;
      4'h7: r = aa >> sh;
      4'h8: r = 64'(sa >>> sh);
      4'h9: r = (sa < sb) ? 64'd1 : 64'd0;
      4'hA: r = (aa < bb) ? 64'd1 : 64'd0;
      4'hB: r = aa * bb;
      4'hC: r = (bb == 0) ? m : aa / bb;
      4'hD: r = (bb == 0) ? aa : aa % bb;
      4'hE: r = bb;
      default: r = '0;
    endcase
    r = r & m;
    res.r = r;
    res.f = (o == 4'hF) ? 4'b0000 : {r[w-1], (r == 64'd0), c, v};
    return res;
  endfunction

  // Scoreboard compare: every cycle, sampled on the falling edge
  exp_t q[$];
  int   cyc = 0;
  int   busy_until = 0;
  logic rst_d = 1'b0;

  always @(negedge clk) begin
    exp_t x;
    logic exp_ov, exp_ir;
    int w;
    cyc++;
    w = sel ? 8 : 64;
    if (rst) begin
      check("rst_in_ready", 64'(obs_ir), 64'd0);
      if (rst_d) begin
        check("rst_out_valid", 64'(obs_ov), 64'd0);
        check("rst_result", obs_r, 64'd0);
        check("rst_flags", 64'(obs_f), 64'd0);
      end
      q.delete();
      busy_until = 0;
    end else begin
      exp_ov = (q.size() > 0) && (q[0].ready_at <= cyc);
      check("out_valid", 64'(obs_ov), 64'(exp_ov));
      if (exp_ov && obs_ov) begin
        check("result", obs_r, q[0].e.r);
        check("flags", 64'(obs_f), 64'(q[0].e.f));
      end
      exp_ir = (cyc > busy_until) && (!exp_ov || out_ready);
      check("in_ready", 64'(obs_ir), 64'(exp_ir));
      if (exp_ov && out_ready) void'(q.pop_front());
      if (in_valid && exp_ir) begin
        x.e = model(w, a, b, op);
        if (op == 4'hB || op == 4'hC || op == 4'hD) begin
          x.ready_at = cyc + w + 1;
          busy_until = cyc + w;
        end else begin
          x.ready_at = cyc + 1;
        end
        q.push_back(x);
      end
    end
    rst_d = rst;
  end

  always @(posedge clk) begin
    #2;
    out_ready = rnd_ready ? ($urandom_range(0, 3) != 0) : ready_force;
  end

  task automatic issue(input logic [63:0] ai, input logic [63:0] bi, input logic [3:0] oi);
    int n = 0;
    a = ai; b = bi; op = oi; in_valid = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (!obs_ir && n < 500);
    check("accept_timeout", 64'(obs_ir), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output logic [63:0] r, output logic [3:0] f, output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!obs_ov && lat < 200);
    check("out_timeout", 64'(obs_ov), 64'd1);
    r = obs_r;
    f = obs_f;
    @(posedge clk); #1;
  endtask

  task automatic do_op(input string name, input logic [63:0] ai, input logic [63:0] bi,
                       input logic [3:0] oi, input logic [63:0] er, input logic [3:0] ef,
                       input int el);
    logic [63:0] r;
    logic [3:0]  f;
    int lat;
    issue(ai, bi, oi);
    wait_out(r, f, lat);
    check({name, "_res"}, r, er);
    check({name, "_flags"}, 64'(f), 64'(ef));
    check({name, "_lat"}, 64'(lat), 64'(el));
  endtask

  function automatic logic [63:0] rnd_val();
    case ($urandom_range(0, 7))
      0: return 64'd0;
      1: return 64'd1;
      2: return '1;
      3: return 64'h8000_0000_0000_0000;
      4: return 64'h7FFF_FFFF_FFFF_FFFF;
      5: return 64'($urandom_range(0, 300));
      default: return {$urandom, $urandom};
    endcase
  endfunction

  task automatic random_phase(input int n);
    rnd_ready = 1'b1;
    repeat (n) begin
      issue(rnd_val(), rnd_val(), 4'($urandom_range(0, 15)));
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end
    rnd_ready = 1'b0;
    repeat (80) begin @(posedge clk); #1; end
  endtask

  task automatic reset_to(input logic s);
    rst = 1'b1;
    sel = s;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b0;
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    res_t m;
    // Hand-computed values pinning the model
    m = model(64, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 4'h0);
    check("model_add_ovf", {m.r[63:4], m.r[3:0] ^ m.f}, 64'h8000_0000_0000_0009);
    m = model(8, 64'h80, 64'd3, 4'h8);
    check("model_sra8", m.r, 64'hF0);
    m = model(64, 64'd100, 64'd0, 4'hC);
    check("model_div0", m.r, '1);
    m = model(8, 64'd7, 64'd6, 4'hB);
    check("model_mul8", m.r, 64'd42);

    // Reset with in_valid held high
    @(posedge clk);
    @(negedge clk);
    check("reset_out_valid", 64'(obs_ov), 64'd0);
    check("reset_result", obs_r, 64'd0);
    check("reset_flags", 64'(obs_f), 64'd0);
    check("reset_in_ready", 64'(obs_ir), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("in_ready_after_reset", 64'(obs_ir), 64'd1);
    @(posedge clk); #1;

    do_op("add_ovf", 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 4'h0, 64'h8000_0000_0000_0000, 4'b1001, 1);
    do_op("add_wrap", '1, 64'd1, 4'h0, 64'd0, 4'b0110, 1);
    do_op("sub_neg", 64'd3, 64'd5, 4'h1, 64'hFFFF_FFFF_FFFF_FFFE, 4'b1000, 1);
    do_op("slt", '1, 64'd1, 4'h9, 64'd1, 4'b0000, 1);
    do_op("sltu", '1, 64'd1, 4'hA, 64'd0, 4'b0100, 1);
    do_op("rsvd", 64'd5, 64'd5, 4'hF, 64'd0, 4'b0000, 1);
    do_op("mul", 64'd7, 64'd6, 4'hB, 64'd42, 4'b0000, 65);
    do_op("divu", 64'd100, 64'd7, 4'hC, 64'd14, 4'b0000, 65);
    do_op("remu", 64'd100, 64'd7, 4'hD, 64'd2, 4'b0000, 65);
    do_op("divu0", 64'd100, 64'd0, 4'hC, '1, 4'b1000, 65);
    do_op("remu0", 64'd100, 64'd0, 4'hD, 64'd100, 4'b0000, 65);

    // Backpressure, then back-to-back accept on release
    ready_force = 1'b0;
    @(posedge clk); #1;
    do_op("bp_add", 64'd1, 64'd2, 4'h0, 64'd3, 4'b0000, 1);
    a = 64'd5; b = 64'd3; op = 4'h4; in_valid = 1'b1;
    repeat (10) begin
      @(negedge clk);
      check("bp_in_ready", 64'(obs_ir), 64'd0);
      check("bp_hold", obs_r, 64'd3);
    end
    @(posedge clk); #1;
    ready_force = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("b2b_valid", 64'(obs_ov), 64'd1);
    check("b2b_result", obs_r, 64'd6);
    @(posedge clk); #1;

    // Reset in the middle of a multiply
    issue(64'd7, 64'd6, 4'hB);
    repeat (19) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (80) begin
      @(negedge clk);
      check("abort_no_out", 64'(obs_ov), 64'd0);
    end
    @(posedge clk); #1;
    do_op("add_after_abort", 64'd2, 64'd2, 4'h0, 64'd4, 4'b0000, 1);

    random_phase(250);

    // Same checks on the 8-bit instance
    reset_to(1'b1);
    do_op("w8_sra", 64'h80, 64'd3, 4'h8, 64'hF0, 4'b1000, 1);
    do_op("w8_add_ovf", 64'h7F, 64'd1, 4'h0, 64'h80, 4'b1001, 1);
    do_op("w8_mul", 64'd7, 64'd6, 4'hB, 64'd42, 4'b0000, 9);
    do_op("w8_divu", 64'd100, 64'd7, 4'hC, 64'd14, 4'b0000, 9);
    do_op("w8_remu", 64'd100, 64'd7, 4'hD, 64'd2, 4'b0000, 9);
    do_op("w8_divu0", 64'd100, 64'd0, 4'hC, 64'hFF, 4'b1000, 9);
    do_op("w8_remu0", 64'd100, 64'd0, 4'hD, 64'd100, 4'b0000, 9);
    random_phase(300);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
- Parametrised, handshaked ALU: the next generation of the 64-bit single-op registered ALU.
- Adds full 16-op decode and status flags.
- Adds iterative multi-cycle multiply/divide/remainder and valid/ready flow control on both sides.
- Sits between operand-fetch and writeback stages of the student datapath; one operation in flight at a time.

Parameters:
WIDTH, 64, operand/result width in bits; legal values are powers of two from 8 to 64
SHW, $clog2(WIDTH), shift-amount width (derived; not overridden)

Ports:
clk  in  1  single clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
a  in  WIDTH  operand A
b  in  WIDTH  operand B
op  in  4  operation select
in_valid  in  1  a/b/op valid
in_ready  out  1  block can accept an operation
result  out  WIDTH  registered result
flags  out  4  {N,Z,C,V} registered with result
out_valid  out  1  result/flags valid
out_ready  in  1  consumer accepts result

Behaviour:
- Reset (rst=1 at a clk edge):
  - result=0, flags=0, out_valid=0.
  - FSM goes to IDLE; iteration counter=0.
  - in_ready reads 0 during the reset cycle.
  - Reset mid-operation aborts the iterative op; no output is produced for it.
- Accept: transfer occurs when in_valid && in_ready at a clk edge; a/b/op are captured on that edge.
  - in_ready = (state==IDLE) && (!out_valid || out_ready). This allows accept in the same cycle the previous result is consumed.
- Op map (single-cycle unless noted):
  - 0 ADD a+b
  - 1 SUB a-b
  - 2 AND
  - 3 OR
  - 4 XOR
  - 5 NOR
  - 6 SLL a<<b[SHW-1:0]
  - 7 SRL logical
  - 8 SRA arithmetic
  - 9 SLT signed, result = 1 or 0
  - A SLTU unsigned, result = 1 or 0
  - B MUL: low WIDTH bits of a*b, iterative shift-add
  - C DIVU: unsigned quotient, iterative restoring
  - D REMU: unsigned remainder, iterative restoring
  - E PASSB: result = b
  - F reserved: result=0, flags=0
- Single-cycle latency: result, flags and out_valid are updated on the edge after acceptance (out_valid visible 1 cycle after accept).
- Iterative latency (B/C/D):
  - FSM IDLE -> BUSY on accept.
  - BUSY processes one bit per cycle for exactly WIDTH cycles (counter 0..WIDTH-1).
  - BUSY -> DONE: result/flags/out_valid registered. out_valid rises exactly WIDTH+1 cycles after the accept edge.
  - DONE -> IDLE in the same edge that loads the output register.
  - in_ready=0 throughout BUSY.
- Divide by zero (b==0):
  - DIVU result = all ones.
  - REMU result = a.
  - Still takes the full WIDTH+1 cycles.
- Flags:
  - N = result[WIDTH-1].
  - Z = (result==0).
  - C: ADD carry-out; SUB = 1 when no borrow (a>=b unsigned); 0 for all other ops.
  - V: signed overflow for ADD/SUB; 0 for all other ops.
  - Reserved op: all flags 0, including Z.
- Output hold: while out_valid && !out_ready, result/flags stay stable and no new op is accepted. out_valid drops on the edge where out_ready=1, unless a new single-cycle op is accepted on that same edge, in which case out_valid stays 1 with the new data.
- Arithmetic is modulo 2^WIDTH; no saturation; shifts use only the low SHW bits of b.

Test Plan:
- Reset: rst high 2 cycles with in_valid=1 -> out_valid=0, result=0, flags=0, in_ready=0 during reset; in_ready=1 the first cycle after.
- ADD overflow (WIDTH=64): a=0x7FFF_FFFF_FFFF_FFFF, b=1, op=0 -> next cycle result=0x8000_0000_0000_0000, flags N=1 Z=0 C=0 V=1. Then a=all-ones, b=1 -> result=0, Z=1 C=1 V=0.
- SUB/SLT: a=3, b=5, op=1 -> result=0xFFFF_FFFF_FFFF_FFFE, N=1 C=0. op=9 with a=-1, b=1 -> 1; op=A with the same operands -> 0.
- Iterative: a=7, b=6, op=B -> in_ready=0 for 64 cycles, out_valid exactly 65 cycles after accept, result=42. a=100, b=7, op=C -> 14; op=D -> 2. b=0, op=C -> all ones; op=D -> 100.
- Backpressure: out_ready=0 for 10 cycles after an ADD result -> result held stable, in_ready=0, a second request is not taken. Raise out_ready with the next op pending -> back-to-back accept, new result the next cycle, no gap in out_valid.
- Reset mid-MUL: assert rst 20 cycles into a MUL -> no out_valid for it; FSM in IDLE. A subsequent ADD 2+2 returns 4 after 1 cycle. Repeat the suite with WIDTH=8: SRA 0x80>>3 = 0xF0, MUL latency 9.
